tag_hit_check_ctrl: RTL and testbench
=====================================

// Module: tag_hit_check_ctrl
// PURPOSE
//   Cache tag lookup controller directly upstream of the sync-read tag RAM. Accepts a
//   read/write request, drives the RAM index, compares the returned {valid,tag}
//   word against the request tag and reports hit/miss. On a write miss it allocates
//   by writing {1'b1,tag} back to the same entry. Keeps saturating hit/miss counters.
// PARAMETERS
//   IDX_W      3   index width; drives tag RAM address (RAM AWIDTH = IDX_W)
//   TAG_W      13  tag width; RAM DWIDTH = TAG_W+1, MSB = valid bit
//   CNT_W      16  width of hit/miss counters
//   CLR_ON_RST 0   1: after reset, sweep all 2**IDX_W entries writing 0 (invalidate)
// PORTS
//   clock      in  1            rising-edge clock
//   reset      in  1            synchronous, active-high
//   req_valid  in  1            request present
//   req_ready  out 1            controller can accept request
//   req_addr   in  TAG_W+IDX_W  {tag, index}
//   req_write  in  1            1 = write access, 0 = read access
//   resp_valid out 1            response present
//   resp_ready in  1            consumer accepts response
//   resp_hit   out 1            stored entry valid and tag equal
//   resp_alloc out 1            write miss caused allocation
//   tram_addr  out IDX_W        to tag RAM addr
//   tram_we    out 1            to tag RAM we
//   tram_din   out TAG_W+1      to tag RAM din
//   tram_dout  in  TAG_W+1      from tag RAM dout (valid 1 cycle after addr sampled)
//   hit_cnt    out CNT_W        saturating hit count
//   miss_cnt   out CNT_W        saturating miss count
// BEHAVIOUR
//   States: INIT, IDLE, LOOKUP, ALLOC, RESP. Reset -> INIT if CLR_ON_RST else IDLE.
//   Reset values: req_ready=0, resp_valid=0, resp_hit=0, resp_alloc=0, tram_we=0,
//     hit_cnt=0, miss_cnt=0, clear counter=0.
//   INIT: tram_addr=clr_cnt, tram_we=1, tram_din=0; clr_cnt++ each cycle; after
//     entry 2**IDX_W-1 -> IDLE. Exactly 2**IDX_W write cycles. req_ready=0.
//   IDLE: req_ready=1; tram_addr=req_addr[IDX_W-1:0] (combinational, so RAM latches it
//     at accept edge). req_valid&req_ready at edge -> latch tag/index/write, -> LOOKUP.
//   LOOKUP: tram_addr=latched index; hit = tram_dout[TAG_W] & (tram_dout[TAG_W-1:0]==tag).
//     hit -> hit_cnt++, else miss_cnt++ (both saturate at all-ones, no wrap).
//     write&!hit -> ALLOC; otherwise -> RESP with resp_hit=hit, resp_alloc=0.
//   ALLOC: one cycle, tram_we=1, tram_addr=latched index, tram_din={1'b1,tag};
//     -> RESP with resp_hit=0, resp_alloc=1. Read miss never allocates; write hit
//     performs no RAM write.
//   RESP: resp_valid=1, resp_hit/resp_alloc stable until resp_valid&resp_ready at
//     edge -> IDLE. req_ready=0 here (one request outstanding; no overlap).
//   Latency (accept edge = E0): hit/read-miss resp_valid high after E1; write miss
//     after E2. Back-to-back min period 3 cycles (hit), 4 (write miss), resp_ready=1.
//   tram_we = (state in {INIT,ALLOC}) & ~reset: reset in ALLOC/INIT cycle suppresses
//     that write. Reset mid-op: drop request, resp_valid=0 next cycle, counters cleared.
//   req_valid while reset high is ignored. tram_we=0 in IDLE/LOOKUP/RESP.
// TESTING (IDX_W=3, TAG_W=13, CLR_ON_RST=0 unless stated)
//   Preload entry 2 = 14'h2ABC; read req_addr={13'h0ABC,3'd2} -> resp_valid after E1,
//     resp_hit=1, resp_alloc=0, tram_we never 1, hit_cnt=1.
//   Entry 5 = 0; write req {13'h0123,3'd5} -> one-cycle tram_we, tram_addr=5,
//     tram_din=14'h2123; resp_hit=0, resp_alloc=1, miss_cnt=1; repeat as read -> hit=1.
//   Entry 3 = 14'h2111; read {13'h0222,3'd3} -> resp_hit=0, resp_alloc=0, no write.
//   Hold resp_ready=0 for 5 cycles -> resp_valid/resp_hit stable, req_ready=0; then
//     pulse resp_ready -> IDLE, next request accepted.
//   CLR_ON_RST=1: release reset -> 8 consecutive tram_we cycles, addr 0..7, din 0,
//     req_ready=0 throughout; afterwards read of entry 2 -> resp_hit=0.
//   Assert reset during ALLOC -> tram_we=0 that cycle, resp_valid=0, entry unchanged;
//     counters preset near max (force 16'hFFFF) -> further hits keep 16'hFFFF.

Source files
------------

// File: rtl/tag_hit_check_ctrl_if.sv
// Request/response handshake bundle between a requester and the tag lookup controller.
// The master drives requests and accepts responses; the slave (controller) does the reverse.
interface tag_hit_check_ctrl_if #(
  parameter int IDX_W = 3,
  parameter int TAG_W = 13
);
  logic                   req_valid;
  logic                   req_ready;
  logic [TAG_W+IDX_W-1:0] req_addr;
  logic                   req_write;
  logic                   resp_valid;
  logic                   resp_ready;
  logic                   resp_hit;
  logic                   resp_alloc;

  modport master (
    output req_valid, req_addr, req_write, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_alloc
  );

  modport slave (
    input  req_valid, req_addr, req_write, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_alloc
  );
endinterface

// File: rtl/tag_hit_check_ctrl.sv
// Tag lookup controller in front of a sync-read tag RAM: hit/miss detection, write-miss
// allocation, optional post-reset invalidate sweep and saturating hit/miss counters.
module tag_hit_check_ctrl #(
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 13,
  parameter int CNT_W      = 16,
  parameter bit CLR_ON_RST = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  tag_hit_check_ctrl_if.slave  bus,
  output logic [IDX_W-1:0]     tram_addr,
  output logic                 tram_we,
  output logic [TAG_W:0]       tram_din,
  input  logic [TAG_W:0]       tram_dout,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt
);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    LOOKUP = 3'd2,
    ALLOC  = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam state_t           RST_STATE = CLR_ON_RST ? INIT : IDLE;
  localparam logic [IDX_W-1:0] IDX_LAST  = {IDX_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t             state_r;
  state_t             state_s;
  logic [TAG_W-1:0]   tag_r;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   clr_cnt_r;
  logic               write_r;
  logic               req_ready_r;
  logic               resp_valid_r;
  logic               resp_hit_r;
  logic               resp_alloc_r;
  logic [CNT_W-1:0]   hit_cnt_r;
  logic [CNT_W-1:0]   miss_cnt_r;
  logic               accept_s;
  logic               hit_s;
  logic               resp_done_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign accept_s    = bus.req_valid & req_ready_r;
  assign hit_s       = tram_dout[TAG_W] & (tram_dout[TAG_W-1:0] == tag_r);
  assign resp_done_s = resp_valid_r & bus.resp_ready;

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_hit   = resp_hit_r;
  assign bus.resp_alloc = resp_alloc_r;
  assign hit_cnt        = hit_cnt_r;
  assign miss_cnt       = miss_cnt_r;

  // Next state and RAM drive; IDLE passes the request index straight through so the RAM
  // samples it on the accept edge, and a write is suppressed while reset is high.
  always_comb begin
    state_s   = state_r;
    tram_addr = idx_r;
    tram_we   = 1'b0;
    tram_din  = {(TAG_W+1){1'b0}};
    case (state_r)
      INIT: begin
        tram_addr = clr_cnt_r;
        tram_we   = ~reset;
        if (clr_cnt_r == IDX_LAST) begin
          state_s = IDLE;
        end else begin
          state_s = INIT;
        end
      end
      IDLE: begin
        tram_addr = bus.req_addr[IDX_W-1:0];
        if (accept_s) begin
          state_s = LOOKUP;
        end else begin
          state_s = IDLE;
        end
      end
      LOOKUP: begin
        if (write_r & ~hit_s) begin
          state_s = ALLOC;
        end else begin
          state_s = RESP;
        end
      end
      ALLOC: begin
        tram_we  = ~reset;
        tram_din = {1'b1, tag_r};
        state_s  = RESP;
      end
      RESP: begin
        if (resp_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = RST_STATE;
      end
    endcase
  end

  // State, request capture and handshake outputs, all registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= RST_STATE;
      clr_cnt_r    <= {IDX_W{1'b0}};
      tag_r        <= {TAG_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      write_r      <= 1'b0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_hit_r   <= 1'b0;
      resp_alloc_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= (state_s == IDLE);
      resp_valid_r <= (state_s == RESP);
      if (state_r == INIT) begin
        clr_cnt_r <= clr_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      if (accept_s) begin
        tag_r   <= bus.req_addr[TAG_W+IDX_W-1:IDX_W];
        idx_r   <= bus.req_addr[IDX_W-1:0];
        write_r <= bus.req_write;
      end
      if ((state_r == LOOKUP) && (state_s == RESP)) begin
        resp_hit_r   <= hit_s;
        resp_alloc_r <= 1'b0;
      end
      if (state_r == ALLOC) begin
        resp_hit_r   <= 1'b0;
        resp_alloc_r <= 1'b1;
      end
    end
  end

  // Saturating hit/miss statistics, one update per lookup.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt_r  <= {CNT_W{1'b0}};
      miss_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == LOOKUP) begin
      if (hit_s) begin
        hit_cnt_r <= sat_inc(hit_cnt_r);
      end else begin
        miss_cnt_r <= sat_inc(miss_cnt_r);
      end
    end
  end

endmodule

// File: tb/tb_tag_hit_check_ctrl.sv
// Bench for tag_hit_check_ctrl: one default instance and one with invalidate sweep and
// 2-bit counters, each with its own behavioural tag RAM and reference model.
module tb_tag_hit_check_ctrl;

  logic clock;
  logic reset_a;
  logic reset_b;

  tag_hit_check_ctrl_if #(.IDX_W(3), .TAG_W(13)) if_a ();
  tag_hit_check_ctrl_if #(.IDX_W(3), .TAG_W(13)) if_b ();

  logic [2:0]  taddr_a, taddr_b;
  logic        twe_a, twe_b;
  logic [13:0] tdin_a, tdin_b;
  logic [13:0] dout_a, dout_b;
  logic [15:0] hcnt_a, mcnt_a;
  logic [1:0]  hcnt_b, mcnt_b;

  tag_hit_check_ctrl #(.IDX_W(3), .TAG_W(13), .CNT_W(16), .CLR_ON_RST(1'b0)) dut_a (
    .clock(clock), .reset(reset_a), .bus(if_a),
    .tram_addr(taddr_a), .tram_we(twe_a), .tram_din(tdin_a), .tram_dout(dout_a),
    .hit_cnt(hcnt_a), .miss_cnt(mcnt_a)
  );

  tag_hit_check_ctrl #(.IDX_W(3), .TAG_W(13), .CNT_W(2), .CLR_ON_RST(1'b1)) dut_b (
    .clock(clock), .reset(reset_b), .bus(if_b),
    .tram_addr(taddr_b), .tram_we(twe_b), .tram_din(tdin_b), .tram_dout(dout_b),
    .hit_cnt(hcnt_b), .miss_cnt(mcnt_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sync-read tag RAMs (read-before-write) with a preload port for the bench
  logic [13:0] ram_a [8];
  logic [13:0] ram_b [8];
  logic        pl_en;
  logic        pl_d;
  logic [2:0]  pl_idx;
  logic [13:0] pl_val;

  always @(posedge clock) begin
    if (pl_en && !pl_d) ram_a[pl_idx] <= pl_val;
    else if (twe_a)     ram_a[taddr_a] <= tdin_a;
    if (pl_en && pl_d)  ram_b[pl_idx] <= pl_val;
    else if (twe_b)     ram_b[taddr_b] <= tdin_b;
    dout_a <= ram_a[taddr_a];
    dout_b <= ram_b[taddr_b];
  end

  int checks = 0;
  int failures = 0;

  // Reference model: stored entries and counters per instance
  logic [13:0] mdl [2][8];
  int          cnt_h [2];
  int          cnt_m [2];

  logic        s_ready, s_rv, s_hit, s_alloc, s_we;
  logic [2:0]  s_addr;
  logic [13:0] s_din;
  logic [15:0] s_hcnt, s_mcnt;

  typedef struct {
    logic [2:0]  idx;
    logic [12:0] tag;
    logic        wr;
    logic        hit;
    logic        alloc;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic sample(input int d);
    if (d == 0) begin
      s_ready = if_a.req_ready; s_rv = if_a.resp_valid; s_hit = if_a.resp_hit;
      s_alloc = if_a.resp_alloc; s_we = twe_a; s_addr = taddr_a; s_din = tdin_a;
      s_hcnt = hcnt_a; s_mcnt = mcnt_a;
    end else begin
      s_ready = if_b.req_ready; s_rv = if_b.resp_valid; s_hit = if_b.resp_hit;
      s_alloc = if_b.resp_alloc; s_we = twe_b; s_addr = taddr_b; s_din = tdin_b;
      s_hcnt = {14'd0, hcnt_b}; s_mcnt = {14'd0, mcnt_b};
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [15:0] a, input logic w);
    if (d == 0) begin
      if_a.req_valid = v; if_a.req_addr = a; if_a.req_write = w;
    end else begin
      if_b.req_valid = v; if_b.req_addr = a; if_b.req_write = w;
    end
  endtask

  task automatic set_rr(input int d, input logic r);
    if (d == 0) if_a.resp_ready = r;
    else        if_b.resp_ready = r;
  endtask

  task automatic preload(input int d, input logic [2:0] i, input logic [13:0] v);
    @(negedge clock);
    pl_en = 1'b1; pl_d = (d == 1); pl_idx = i; pl_val = v;
    @(posedge clock);
    #1 pl_en = 1'b0;
    mdl[d][i] = v;
  endtask

  function automatic logic model_hit(input int d, input logic [2:0] idx, input logic [12:0] tag);
    return mdl[d][idx][13] && (mdl[d][idx][12:0] == tag);
  endfunction

  task automatic model_update(input int d, input logic [2:0] idx, input logic [12:0] tag, input logic wr);
    logic h;
    int   cmax;
    cmax = (d == 1) ? 3 : 65535;
    h = model_hit(d, idx, tag);
    if (h) cnt_h[d] = (cnt_h[d] >= cmax) ? cmax : cnt_h[d] + 1;
    else   cnt_m[d] = (cnt_m[d] >= cmax) ? cmax : cnt_m[d] + 1;
    if (wr && !h) mdl[d][idx] = {1'b1, tag};
  endtask

  // Issue one request and check the response; leaves the response pending (resp_ready=0)
  task automatic run_req(input int d, input logic [2:0] idx, input logic [12:0] tag,
                         input logic wr, input logic eh, input logic ea);
    int lat;
    int wes;
    int waited;
    waited = 0;
    set_rr(d, 1'b0);
    @(negedge clock); sample(d);
    while (!s_ready && waited < 20) begin
      @(negedge clock); sample(d); waited++;
    end
    chk("req_ready_wait", s_ready, 1);
    drive(d, 1'b1, {tag, idx}, wr);
    @(posedge clock);
    @(negedge clock);
    drive(d, 1'b0, 16'd0, 1'b0);
    sample(d);
    wes = s_we ? 1 : 0;
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock); sample(d);
      if (s_we) begin
        wes++;
        chk("alloc_addr", s_addr, idx);
        chk("alloc_din", s_din, {1'b1, tag});
      end
      if (s_rv) begin
        lat = c;
        break;
      end
    end
    chk("latency", lat, ea ? 2 : 1);
    chk("resp_hit", s_hit, eh);
    chk("resp_alloc", s_alloc, ea);
    chk("ram_writes", wes, ea ? 1 : 0);
    chk("ready_in_resp", s_ready, 0);
    model_update(d, idx, tag, wr);
    chk("hit_cnt", s_hcnt, cnt_h[d]);
    chk("miss_cnt", s_mcnt, cnt_m[d]);
  endtask

  task automatic finish_resp(input int d);
    @(negedge clock);
    set_rr(d, 1'b1);
    @(posedge clock);
    @(negedge clock); sample(d);
    chk("resp_valid_drop", s_rv, 0);
    chk("ready_after_resp", s_ready, 1);
    set_rr(d, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [12:0] tags [4];
    logic [2:0]  r_idx;
    logic [12:0] r_tag;
    logic        r_wr;
    logic        r_h;

    tags[0] = 13'h0ABC; tags[1] = 13'h0123; tags[2] = 13'h1FFF; tags[3] = 13'h0005;
    vt[0] = '{3'd2, 13'h0ABC, 1'b0, 1'b1, 1'b0};
    vt[1] = '{3'd5, 13'h0123, 1'b1, 1'b0, 1'b1};
    vt[2] = '{3'd5, 13'h0123, 1'b0, 1'b1, 1'b0};
    vt[3] = '{3'd3, 13'h0222, 1'b0, 1'b0, 1'b0};
    vt[4] = '{3'd2, 13'h0ABC, 1'b1, 1'b1, 1'b0};
    vt[5] = '{3'd3, 13'h0111, 1'b0, 1'b1, 1'b0};

    reset_a = 1'b1; reset_b = 1'b1; pl_en = 1'b0; pl_d = 1'b0; pl_idx = 3'd0; pl_val = 14'd0;
    drive(0, 1'b0, 16'd0, 1'b0); drive(1, 1'b0, 16'd0, 1'b0);
    set_rr(0, 1'b0); set_rr(1, 1'b0);
    cnt_h[0] = 0; cnt_m[0] = 0; cnt_h[1] = 0; cnt_m[1] = 0;

    // Reset state, with a request offered during reset that must be ignored
    drive(0, 1'b1, {13'h0ABC, 3'd2}, 1'b1);
    repeat (3) @(negedge clock);
    sample(0);
    chk("rst_req_ready", s_ready, 0);
    chk("rst_resp_valid", s_rv, 0);
    chk("rst_resp_hit", s_hit, 0);
    chk("rst_resp_alloc", s_alloc, 0);
    chk("rst_tram_we", s_we, 0);
    chk("rst_hit_cnt", s_hcnt, 0);
    chk("rst_miss_cnt", s_mcnt, 0);
    sample(1);
    chk("rst_b_tram_we", s_we, 0);
    drive(0, 1'b0, 16'd0, 1'b0);

    for (int i = 0; i < 8; i++) preload(0, i[2:0], 14'h0);
    preload(0, 3'd2, 14'h2ABC);
    preload(0, 3'd3, 14'h2111);
    preload(1, 3'd2, 14'h2ABC);
    @(negedge clock); reset_a = 1'b0;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_req(0, vt[i].idx, vt[i].tag, vt[i].wr, vt[i].hit, vt[i].alloc);
      finish_resp(0);
    end

    // Response backpressure: outputs hold while resp_ready stays low
    run_req(0, 3'd2, 13'h0ABC, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); sample(0);
      chk("stall_valid", s_rv, 1);
      chk("stall_hit", s_hit, 1);
      chk("stall_ready", s_ready, 0);
    end
    finish_resp(0);
    run_req(0, 3'd3, 13'h0222, 1'b0, 1'b0, 1'b0);
    finish_resp(0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      r_idx = 3'($urandom_range(0, 7));
      r_tag = tags[$urandom_range(0, 3)];
      r_wr  = 1'($urandom_range(0, 1));
      r_h   = model_hit(0, r_idx, r_tag);
      run_req(0, r_idx, r_tag, r_wr, r_h, r_wr && !r_h);
      finish_resp(0);
    end

    // Reset during the allocation cycle
    preload(0, 3'd6, 14'h0);
    @(negedge clock);
    drive(0, 1'b1, {13'h0777, 3'd6}, 1'b1);
    @(posedge clock);
    @(negedge clock); drive(0, 1'b0, 16'd0, 1'b0);
    @(negedge clock); sample(0);
    chk("alloc_we_before_rst", s_we, 1);
    reset_a = 1'b1;
    #1 sample(0);
    chk("alloc_we_in_rst", s_we, 0);
    @(negedge clock); sample(0);
    chk("midrst_resp_valid", s_rv, 0);
    chk("midrst_req_ready", s_ready, 0);
    chk("midrst_hit_cnt", s_hcnt, 0);
    chk("midrst_miss_cnt", s_mcnt, 0);
    chk("midrst_entry6", ram_a[6], 14'h0);
    reset_a = 1'b0;
    cnt_h[0] = 0; cnt_m[0] = 0;
    run_req(0, 3'd6, 13'h0777, 1'b1, 1'b0, 1'b1);
    finish_resp(0);

    // Invalidate sweep after reset release
    @(negedge clock); reset_b = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      sample(1);
      chk("sweep_we", s_we, 1);
      chk("sweep_addr", s_addr, i);
      chk("sweep_din", s_din, 14'h0);
      chk("sweep_ready", s_ready, 0);
      @(negedge clock);
    end
    sample(1);
    chk("sweep_done_we", s_we, 0);
    chk("sweep_entry2", ram_b[2], 14'h0);
    for (int i = 0; i < 8; i++) mdl[1][i] = 14'h0;

    // Cleared entry misses; then 2-bit counters saturate
    run_req(1, 3'd2, 13'h0ABC, 1'b0, 1'b0, 1'b0); finish_resp(1);
    run_req(1, 3'd2, 13'h0ABC, 1'b1, 1'b0, 1'b1); finish_resp(1);
    for (int i = 0; i < 4; i++) begin
      run_req(1, 3'd2, 13'h0ABC, 1'b0, 1'b1, 1'b0); finish_resp(1);
    end
    run_req(1, 3'd0, 13'h0001, 1'b1, 1'b0, 1'b1); finish_resp(1);
    run_req(1, 3'd1, 13'h0001, 1'b1, 1'b0, 1'b1); finish_resp(1);
    sample(1);
    chk("sat_hit_cnt", s_hcnt, 3);
    chk("sat_miss_cnt", s_mcnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
